// File: rtl/bnn_frame_loader.sv
// Streams binary pixel rows into the frame that feeds bnn_top, waits for the net to settle,
// then captures the three class scores and their argmax. Define BNN_FRAME_DBUF_EN for a shadow frame buffer.
module bnn_frame_loader #(
    parameter int SETTLE_CYCLES = 16,
    parameter int ROWS          = 64,
    parameter int COLS          = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       row_valid_i,
    input  logic [COLS-1:0]            row_data_i,
    output logic                       row_ready_o,
    output logic [ROWS-1:0][COLS-1:0]  layer_o,
    input  logic [2:0][6:0]            net_res_i,
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output logic [1:0]                 res_class_o,
    output logic [2:0][6:0]            res_scores_o,
    output logic                       busy_o
);

    localparam int            RW          = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RW-1:0] LAST_ROW    = RW'(ROWS - 1);
    localparam logic [7:0]    SETTLE_INIT = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {LOAD, SETTLE, RESULT} state_t;

    state_t     state;
    logic [7:0] settle_cnt;
    logic       scores_taken;
    logic       run;
    logic       row_accept;
    logic [1:0] next_class;
    logic [6:0] best;

`ifdef BNN_FRAME_DBUF_EN
    logic [ROWS-1:0][COLS-1:0] shadow;
    logic [RW-1:0]             shadow_cnt;
    logic                      shadow_full;

    assign row_ready_o = run && !shadow_full;
`else
    logic [RW-1:0] row_cnt;

    assign row_ready_o = run && (state == LOAD);
`endif

    assign row_accept = row_valid_i && row_ready_o;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        next_class = 2'd0;
        best       = net_res_i[0];
        if (net_res_i[1] > best) begin
            next_class = 2'd1;
            best       = net_res_i[1];
        end
        if (net_res_i[2] > best) begin
            next_class = 2'd2;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= LOAD;
            settle_cnt   <= '0;
            scores_taken <= 1'b0;
            run          <= 1'b0;
            layer_o      <= '0;
            res_scores_o <= '0;
            res_class_o  <= '0;
            res_valid_o  <= 1'b0;
            busy_o       <= 1'b0;
`ifdef BNN_FRAME_DBUF_EN
            shadow       <= '0;
            shadow_cnt   <= '0;
            shadow_full  <= 1'b0;
`else
            row_cnt      <= '0;
`endif
        end else begin
            run <= 1'b1;
`ifdef BNN_FRAME_DBUF_EN
            if (row_accept) begin
                shadow[shadow_cnt] <= row_data_i;
                shadow_cnt         <= (shadow_cnt == LAST_ROW) ? '0 : shadow_cnt + 1'b1;
                if (shadow_cnt == LAST_ROW) begin
                    shadow_full <= 1'b1;
                end
            end
`else
            if (row_accept) begin
                layer_o[row_cnt] <= row_data_i;
                row_cnt          <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
            end
`endif
            case (state)
                LOAD: begin
`ifdef BNN_FRAME_DBUF_EN
                    if (shadow_full) begin
                        layer_o     <= shadow;
                        shadow_full <= 1'b0;
                        settle_cnt  <= SETTLE_INIT;
                        state       <= SETTLE;
                        busy_o      <= 1'b1;
                    end
`else
                    if (row_accept && row_cnt == LAST_ROW) begin
                        settle_cnt <= SETTLE_INIT;
                        state      <= SETTLE;
                        busy_o     <= 1'b1;
                    end
`endif
                end
                // Scores are sampled once the count expires; the result is offered one edge later.
                SETTLE: begin
                    if (settle_cnt != 8'd0) begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end else if (!scores_taken) begin
                        res_scores_o <= net_res_i;
                        res_class_o  <= next_class;
                        scores_taken <= 1'b1;
                    end else begin
                        scores_taken <= 1'b0;
                        state        <= RESULT;
                        res_valid_o  <= 1'b1;
                    end
                end
                RESULT: begin
                    if (res_ready_i) begin
                        state       <= LOAD;
                        res_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_frame_loader.sv
// Self-checking bench for bnn_frame_loader: a timestamp-based frame model checked every cycle,
// plus directed frames, a mid-frame reset and 100 frames with random valid/ready toggling.
module tb_bnn_frame_loader;

    localparam int ROWS = 64;
    localparam int COLS = 64;
    localparam int S    = 16;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      row_valid;
    logic [COLS-1:0]           row_data;
    logic                      row_ready_o;
    logic [ROWS-1:0][COLS-1:0] layer_o;
    logic [2:0][6:0]           net_res;
    logic                      res_valid_o;
    logic                      res_ready;
    logic [1:0]                res_class_o;
    logic [2:0][6:0]           res_scores_o;
    logic                      busy_o;

    int n_checks = 0;
    int n_bad    = 0;

    bit              m_run;
    bit              m_have;
    bit              m_acc;
    bit              m_hs;
    int              m_rows;
    int              m_wait;
    logic [2:0][6:0] m_scores;
    logic [1:0]      m_class;
    logic [COLS-1:0] m_layer [ROWS];

    always #5 clk = ~clk;

    bnn_frame_loader #(.SETTLE_CYCLES(S), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .row_valid_i  (row_valid),
        .row_data_i   (row_data),
        .row_ready_o  (row_ready_o),
        .layer_o      (layer_o),
        .net_res_i    (net_res),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready),
        .res_class_o  (res_class_o),
        .res_scores_o (res_scores_o),
        .busy_o       (busy_o)
    );

    function automatic logic [63:0] frameRow(input int f, input int r);
        logic [63:0] x;
        x = {32'(f), 32'(r)} * 64'h9E37_79B9_7F4A_7C15 + 64'h1234_5678;
        return x ^ (x >> 29);
    endfunction

    function automatic logic [1:0] refArgmax(input logic [2:0][6:0] s);
        int         best;
        logic [1:0] idx;
        best = -1;
        idx  = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (int'(s[i]) > best) begin
                best = int'(s[i]);
                idx  = 2'(i);
            end
        end
        return idx;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Frame model: a frame is pending from its last accepted row until its result handshake;
    // the result appears S+1 edges after that last row.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run    <= 1'b0;
            m_have   <= 1'b0;
            m_acc    <= 1'b0;
            m_hs     <= 1'b0;
            m_rows   <= 0;
            m_wait   <= -1;
            m_scores <= '0;
            m_class  <= '0;
            for (int r = 0; r < ROWS; r++) m_layer[r] <= '0;
        end else begin
            m_run <= 1'b1;
            m_acc <= m_run && !(m_wait >= 0 || m_have) && row_valid;
            m_hs  <= m_have && res_ready;
            if (m_have && res_ready) begin
                m_have <= 1'b0;
            end else if (m_wait >= 0) begin
                if (m_wait == S) begin
                    m_have   <= 1'b1;
                    m_scores <= net_res;
                    m_class  <= refArgmax(net_res);
                    m_wait   <= -1;
                end else begin
                    m_wait <= m_wait + 1;
                end
            end else if (m_run && !m_have && row_valid) begin
                m_layer[m_rows] <= row_data;
                if (m_rows == ROWS - 1) begin
                    m_rows <= 0;
                    m_wait <= 0;
                end else begin
                    m_rows <= m_rows + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        int bad_row;
        if (rst_n) begin
            checkOutput("row_ready", 64'(row_ready_o), 64'(m_run && !(m_wait >= 0 || m_have)));
            checkOutput("busy", 64'(busy_o), 64'(m_wait >= 0 || m_have));
            checkOutput("res_valid", 64'(res_valid_o), 64'(m_have));
            if (m_have) begin
                checkOutput("res_class", 64'(res_class_o), 64'(m_class));
                checkOutput("res_scores", 64'(res_scores_o), 64'(m_scores));
            end
            bad_row = -1;
            for (int r = ROWS - 1; r >= 0; r--) begin
                if (layer_o[r] !== m_layer[r]) bad_row = r;
            end
            n_checks++;
            if (bad_row >= 0) begin
                n_bad++;
                $display("[TB] FAIL layer row %0d: got %h, expected %h", bad_row, layer_o[bad_row], m_layer[bad_row]);
            end
        end
    end

    task automatic checkResetValues(input string tag);
        int nz;
        nz = 0;
        for (int r = 0; r < ROWS; r++) if (layer_o[r] !== '0) nz++;
        checkOutput({tag, "_row_ready"}, 64'(row_ready_o), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy_o), 64'd0);
        checkOutput({tag, "_res_valid"}, 64'(res_valid_o), 64'd0);
        checkOutput({tag, "_res_class"}, 64'(res_class_o), 64'd0);
        checkOutput({tag, "_res_scores"}, 64'(res_scores_o), 64'd0);
        checkOutput({tag, "_layer_nonzero_rows"}, 64'(nz), 64'd0);
    endtask

    // Sends one frame, waits for its result, holds res_ready off for 'hold' cycles, then handshakes.
    task automatic applyStimulus(input int f, input bit rand_valid, input bit rand_ready,
                                 input int hold, input bit pin);
        int r, budget, lat, rdy_hi;
        bit done;
        r = 0; budget = 0; rdy_hi = 0; lat = 0; done = 1'b0;
        while (r < ROWS && budget < 2000) begin
            row_data  = frameRow(f, r);
            row_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            rdy_hi += int'(row_ready_o);
            @(posedge clk); #1;
            budget++;
            if (m_acc) r++;
        end
        checkOutput("frame_rows_accepted", 64'(r), 64'(ROWS));
        if (pin) checkOutput("ready_cycles", 64'(rdy_hi), 64'(ROWS));
        row_data = frameRow(f + 1, 0);
        while (!(pin ? res_valid_o : m_have) && lat < 100) begin
            row_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (pin) checkOutput("result_latency", 64'(lat), 64'(S + 1));
        checkOutput("result_seen", 64'(m_have), 64'd1);
        for (int i = 0; i < hold && !done; i++) begin
            row_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
            done = m_hs;
        end
        if (pin) begin
            checkOutput("hold_row_ready", 64'(row_ready_o), 64'd0);
            checkOutput("hold_class", 64'(res_class_o), 64'd1);
            checkOutput("hold_score0", 64'(res_scores_o[0]), 64'd5);
            checkOutput("hold_score1", 64'(res_scores_o[1]), 64'd90);
            checkOutput("hold_score2", 64'(res_scores_o[2]), 64'd90);
            checkOutput("model_class", 64'(m_class), 64'd1);
        end
        if (!done) begin
            res_ready = 1'b1;
            @(posedge clk); #1;
            done = m_hs;
        end
        res_ready = 1'b0;
        checkOutput("handshake", 64'(done), 64'd1);
    endtask

    initial begin
        int r;
        rst_n     = 1'b0;
        row_valid = 1'b0;
        row_data  = '0;
        res_ready = 1'b0;
        net_res   = '0;
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("por");
        rst_n = 1'b1;

        net_res[0] = 7'd5;
        net_res[1] = 7'd90;
        net_res[2] = 7'd90;
        applyStimulus(0, 1'b0, 1'b0, 50, 1'b1);

        r = 0;
        while (r < 30) begin
            row_data  = frameRow(1, r);
            row_valid = 1'b1;
            @(posedge clk); #1;
            if (m_acc) r++;
        end
        #2 rst_n = 1'b0;
        #1 checkResetValues("midframe");
        row_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        net_res[0] = 7'd10;
        net_res[1] = 7'd3;
        net_res[2] = 7'd77;
        applyStimulus(2, 1'b0, 1'b0, 0, 1'b0);
        checkOutput("frame2_row0", layer_o[0], frameRow(2, 0));
        checkOutput("frame2_row63", layer_o[ROWS-1], frameRow(2, ROWS - 1));

        for (int f = 3; f < 103; f++) begin
            for (int k = 0; k < 3; k++) net_res[k] = 7'($urandom_range(0, (f % 3 == 0) ? 3 : 127));
            applyStimulus(f, 1'b1, 1'b1, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #900000;
        n_checks++;
        n_bad++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
